mem_ctrl: RTL
=============

# mem_ctrl

Memory controller directly downstream of the fetch stage: services fetch's instruction-miss requests and the load/store unit's data requests over a single byte-wide RAM port. Converts 1/2/4-byte accesses into sequential byte transactions, arbitrates between the two requesters, and returns assembled words with a one-cycle done pulse. Fetch consumes `inst_done`/`inst_data` as its memory-instruction-valid/instruction inputs.

## Interface
Parameters:
- `ADDR_W`, 32, address width
- `DATA_W`, 32, word width

Ports:
- `clk` in 1: clock
- `rst` in 1: reset, synchronous, active-high
- `rdy` in 1: global enable; low freezes all state
- `inst_req` in 1: one-cycle request pulse from fetch, already qualified by icache miss
- `inst_addr` in 32: instruction address, valid with `inst_req`
- `inst_done` out 1: one-cycle pulse, `inst_data` valid
- `inst_data` out 32: assembled instruction, little-endian
- `data_req` in 1: one-cycle request pulse from LSU
- `data_we` in 1: 1 = store, 0 = load
- `data_width` in 2: 00 byte, 01 half, 10 word; 11 is illegal and treated as word
- `data_addr` in 32: byte address
- `data_wdata` in 32: store data, low bytes used
- `data_done` out 1: one-cycle pulse on load data valid or store complete
- `data_rdata` out 32: load data, zero-extended
- `ram_din` in 8: RAM read byte
- `ram_dout` out 8: RAM write byte
- `ram_addr` out 32: RAM byte address
- `ram_wr` out 1: RAM write strobe
- `io_buffer_full` in 1: present only with `MEM_IO_STALL_EN`

## Operation
- Reset values: `inst_done`=0, `data_done`=0, `ram_wr`=0, `ram_addr`=0, `ram_dout`=0, `inst_data`=0, `data_rdata`=0. Pending flags cleared, state IDLE.
- Each request pulse latches its address, width, we, and wdata into a per-port pending slot. At most one outstanding request per port. A second pulse while that port is pending violates the protocol, and behaviour is undefined.
- States:
  - IDLE: if data is pending, go to READ or WRITE for data; otherwise, if inst is pending, go to READ with width word. Data has priority.
  - READ: byte counter runs 0..n-1.
  - WRITE: byte counter runs 0..n-1.
- Read: RAM latency is 1 cycle. Byte k is driven at `ram_addr` = base+k, and `ram_din` returns it the next cycle. That byte lands in bits [8k+7:8k]. After byte n-1 is captured: pulse done, write the result register, return to IDLE.
- Write: `ram_wr`=1, `ram_addr`=base+k, `ram_dout`=wdata[8k+7:8k] for k=0..n-1 on consecutive cycles. Then `ram_wr` drops to 0, `data_done` pulses, and state returns to IDLE.
- Address arithmetic is modulo 2^32; base+k wraps.
- A request arriving in the same cycle as another port's done is latched normally.
- Simultaneous `inst_req` and `data_req` while IDLE: data is served first.
- `rst` mid-transaction aborts it. No done pulse is issued and pending requests are dropped.
- `rdy`=0: no state, counter, or output register changes. Request pulses arriving while `rdy`=0 are lost, so requesters hold off.

## Timing
- Request in cycle 0 with controller IDLE:
  - First address is driven in cycle 1.
  - n-byte read: done high in cycle n+2 (byte 3, word 6).
  - n-byte write: `ram_wr` high in cycles 1..n, done high in cycle n+1.
- After a done cycle, the next pending transaction drives its first address one cycle later.
- `inst_data`/`data_rdata` hold their value until the next completion on that port.
- Done outputs are registered.

## Configuration
- `MEM_IO_STALL_EN` defined:
  - `io_buffer_full` port exists.
  - A pending store whose address has bits [17:16]=2'b11 does not leave IDLE while `io_buffer_full`=1. An inst request may be served meanwhile.
  - After every IO store, the controller spends one extra IDLE cycle before arbitrating.
- Undefined: the port is absent and IO stores are treated like any other store.

## Structure
- Shared package `mem_pkg`:
  - width codes `MEM_BYTE`/`MEM_HALF`/`MEM_WORD`
  - state encoding `MEM_IDLE`/`MEM_READ`/`MEM_WRITE`
  - `IO_ADDR_HI` = 2'b11
  - byte-count function width→n
- One sub-module: `mem_req_slot`, the per-port pending latch (valid, addr, width, we, wdata; set on pulse, cleared on grant), instantiated twice.

## Test plan
- `inst_req`, addr 0x1000, RAM word 0x00A00093 → `ram_addr` 0x1000..0x1003 in cycles 1–4; `inst_done` in cycle 6 with `inst_data`=0x00A00093.
- `data_req` byte load, addr 0x2003, RAM 0xF7 → `data_done` in cycle 3, `data_rdata`=0x000000F7.
- Half store 0xBEEF to 0x2000 → `ram_wr` in cycles 1–2 with (0x2000, 0xEF) then (0x2001, 0xBE); `data_done` in cycle 3.
- `inst_req` and word load issued in the same cycle → data completes in cycle 6; inst first address in cycle 7; `inst_done` in cycle 12.
- `rst` in cycle 3 of a word read → no done pulse; all outputs at reset values next cycle.
- With `MEM_IO_STALL_EN`: byte store to 0x30000 while `io_buffer_full`=1 for 5 cycles → `ram_wr` first high the cycle after full deasserts.

Source files
------------

// File: rtl/mem_pkg.sv
// mem_pkg: shared width codes, FSM states and byte-count helper for the memory controller
package mem_pkg;
    localparam logic [1:0] MEM_BYTE   = 2'b00;
    localparam logic [1:0] MEM_HALF   = 2'b01;
    localparam logic [1:0] MEM_WORD   = 2'b10;
    localparam logic [1:0] IO_ADDR_HI = 2'b11;

    typedef enum logic [1:0] {MEM_IDLE, MEM_READ, MEM_WRITE} mem_state_e;

    // width code 2'b11 is illegal and falls through to a full word
    function automatic logic [2:0] byte_count(input logic [1:0] width);
        return width == MEM_BYTE ? 3'd1 : width == MEM_HALF ? 3'd2 : 3'd4;
    endfunction
endpackage

// File: rtl/mem_ctrl_if.sv
// mem_ctrl_if: fetch, LSU and byte-wide RAM signals of the memory controller
interface mem_ctrl_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
    logic              inst_req;
    logic [ADDR_W-1:0] inst_addr;
    logic              inst_done;
    logic [DATA_W-1:0] inst_data;
    logic              data_req;
    logic              data_we;
    logic [1:0]        data_width;
    logic [ADDR_W-1:0] data_addr;
    logic [DATA_W-1:0] data_wdata;
    logic              data_done;
    logic [DATA_W-1:0] data_rdata;
    logic [7:0]        ram_din;
    logic [7:0]        ram_dout;
    logic [ADDR_W-1:0] ram_addr;
    logic              ram_wr;

    modport master (
        output inst_req, inst_addr, data_req, data_we, data_width, data_addr, data_wdata, ram_din,
        input  inst_done, inst_data, data_done, data_rdata, ram_dout, ram_addr, ram_wr
    );
    modport slave (
        input  inst_req, inst_addr, data_req, data_we, data_width, data_addr, data_wdata, ram_din,
        output inst_done, inst_data, data_done, data_rdata, ram_dout, ram_addr, ram_wr
    );
endinterface

// File: rtl/mem_req_slot.sv
// mem_req_slot: one-deep pending latch for a requester, bypassing a pulse arriving this cycle
module mem_req_slot #(parameter int ADDR_W = 32, parameter int DATA_W = 32) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy,
    input  logic              req,
    input  logic              grant,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [1:0]        req_width,
    input  logic              req_we,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              pend,
    output logic [ADDR_W-1:0] pend_addr,
    output logic [1:0]        pend_width,
    output logic              pend_we,
    output logic [DATA_W-1:0] pend_wdata
);
    logic              valid;
    logic [ADDR_W-1:0] addr;
    logic [1:0]        width;
    logic              we;
    logic [DATA_W-1:0] wdata;

    assign pend       = valid | req;
    assign pend_addr  = valid ? addr : req_addr;
    assign pend_width = valid ? width : req_width;
    assign pend_we    = valid ? we : req_we;
    assign pend_wdata = valid ? wdata : req_wdata;

    // hold a request pulse until the arbiter grants it; pulses while frozen are lost
    always_ff @(posedge clk)
        if (rst) valid <= 1'b0;
        else if (rdy) begin
            valid <= (valid | req) & ~grant;
            if (req & ~valid) begin
                addr  <= req_addr;
                width <= req_width;
                we    <= req_we;
                wdata <= req_wdata;
            end
        end
endmodule

// File: rtl/mem_ctrl.sv
// mem_ctrl: serialises fetch and LSU requests onto a byte-wide RAM; MEM_IO_STALL_EN adds io_buffer_full back-pressure on IO stores
module mem_ctrl
    import mem_pkg::*;
#(parameter int ADDR_W = 32, parameter int DATA_W = 32) (
    input  logic clk,
    input  logic rst,
    input  logic rdy,
`ifdef MEM_IO_STALL_EN
    input  logic io_buffer_full,
`endif
    mem_ctrl_if.slave bus
);
    mem_state_e        state;
    logic              i_pend, d_pend, i_we, d_we, sel_we;
    logic              take_inst, take_data, data_io, data_block;
    logic              io_hold, cur_io, is_inst;
    logic [1:0]        i_width, d_width, sel_width, cap_idx;
    logic [2:0]        cnt, cnt_inc, n;
    logic [ADDR_W-1:0] i_addr, d_addr, sel_addr, base;
    logic [DATA_W-1:0] i_wdata, d_wdata, sel_wdata, wbuf, rbuf, rd_word;

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_inst_slot (
        .clk(clk), .rst(rst), .rdy(rdy), .req(bus.inst_req), .grant(take_inst),
        .req_addr(bus.inst_addr), .req_width(MEM_WORD), .req_we(1'b0), .req_wdata('0),
        .pend(i_pend), .pend_addr(i_addr), .pend_width(i_width), .pend_we(i_we), .pend_wdata(i_wdata)
    );

    mem_req_slot #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_data_slot (
        .clk(clk), .rst(rst), .rdy(rdy), .req(bus.data_req), .grant(take_data),
        .req_addr(bus.data_addr), .req_width(bus.data_width), .req_we(bus.data_we), .req_wdata(bus.data_wdata),
        .pend(d_pend), .pend_addr(d_addr), .pend_width(d_width), .pend_we(d_we), .pend_wdata(d_wdata)
    );

`ifdef MEM_IO_STALL_EN
    assign data_io    = d_we & (d_addr[17:16] == IO_ADDR_HI);
    assign data_block = data_io & io_buffer_full;
`else
    assign data_io    = 1'b0;
    assign data_block = 1'b0;
`endif

    // arbitration: data wins unless its IO store is stalled; nothing is granted in the post-IO idle cycle
    always_comb begin
        take_data = rdy & (state == MEM_IDLE) & ~io_hold & d_pend & ~data_block;
        take_inst = rdy & (state == MEM_IDLE) & ~io_hold & i_pend & ~take_data;
        sel_addr  = take_data ? d_addr : i_addr;
        sel_width = take_data ? d_width : i_width;
        sel_we    = take_data ? d_we : i_we;
        sel_wdata = take_data ? d_wdata : i_wdata;
        cnt_inc   = cnt + 3'd1;
        cap_idx   = cnt[1:0] - 2'd1;
        rd_word   = rbuf;
        rd_word[{cap_idx, 3'b000} +: 8] = bus.ram_din;
    end

    // sequencer: byte-serial reads (counter runs one past the last address to catch RAM latency) and writes
    always_ff @(posedge clk)
        if (rst) begin
            state          <= MEM_IDLE;
            cnt            <= '0;
            n              <= '0;
            base           <= '0;
            wbuf           <= '0;
            rbuf           <= '0;
            is_inst        <= 1'b0;
            io_hold        <= 1'b0;
            cur_io         <= 1'b0;
            bus.inst_done  <= 1'b0;
            bus.data_done  <= 1'b0;
            bus.inst_data  <= '0;
            bus.data_rdata <= '0;
            bus.ram_addr   <= '0;
            bus.ram_dout   <= '0;
            bus.ram_wr     <= 1'b0;
        end else if (rdy) begin
            bus.inst_done <= 1'b0;
            bus.data_done <= 1'b0;
            case (state)
                MEM_IDLE: begin
                    io_hold <= 1'b0;
                    if (take_data | take_inst) begin
                        base         <= sel_addr;
                        n            <= byte_count(sel_width);
                        wbuf         <= sel_wdata;
                        rbuf         <= '0;
                        cnt          <= '0;
                        is_inst      <= take_inst;
                        cur_io       <= take_data & data_io;
                        bus.ram_addr <= sel_addr;
                        bus.ram_wr   <= sel_we;
                        bus.ram_dout <= sel_wdata[7:0];
                        state        <= sel_we ? MEM_WRITE : MEM_READ;
                    end
                end
                MEM_READ: begin
                    if (cnt != 3'd0) rbuf <= rd_word;
                    if (cnt == n) begin
                        state <= MEM_IDLE;
                        if (is_inst) begin
                            bus.inst_done <= 1'b1;
                            bus.inst_data <= rd_word;
                        end else begin
                            bus.data_done  <= 1'b1;
                            bus.data_rdata <= rd_word;
                        end
                    end else begin
                        cnt <= cnt_inc;
                        if (cnt_inc < n) bus.ram_addr <= base + ADDR_W'(cnt_inc);
                    end
                end
                MEM_WRITE: begin
                    if (cnt == n - 3'd1) begin
                        bus.ram_wr    <= 1'b0;
                        bus.data_done <= 1'b1;
                        io_hold       <= cur_io;
                        state         <= MEM_IDLE;
                    end else begin
                        cnt          <= cnt_inc;
                        bus.ram_addr <= base + ADDR_W'(cnt_inc);
                        bus.ram_dout <= wbuf[{cnt_inc[1:0], 3'b000} +: 8];
                    end
                end
                default: state <= MEM_IDLE;
            endcase
        end
endmodule
